// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encoding and event packing for the PS/2 keyboard receive path.
// Events are {ext, brk, code[7:0]}.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int         EVT_EXT = 9;
  localparam int         EVT_BRK = 8;
  localparam int         EVT_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  function automatic logic [EVT_W-1:0] mk_evt(input logic ext, input logic brk,
                                              input logic [7:0] code);
    logic [EVT_W-1:0] e;
    e          = '0;
    e[EVT_EXT] = ext;
    e[EVT_BRK] = brk;
    e[7:0]     = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Byte-receiver/CPU side bundle of the keyboard controller.
// The master drives the strobes; the slave is the controller.
interface ps2_kbd_ctrl_if #(parameter int DEPTH = 8);

  localparam int CW = $clog2(DEPTH + 1);

  logic          rx_valid;
  logic [7:0]    rx_code;
  logic          rd_en;
  logic          irq_en;
  logic          ovf_clr;
  logic [9:0]    evt_data;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          irq;

  modport master (
    output rx_valid, rx_code, rd_en, irq_en, ovf_clr,
    input  evt_data, empty, count, overflow, irq
  );

  modport slave (
    input  rx_valid, rx_code, rd_en, irq_en, ovf_clr,
    output evt_data, empty, count, overflow, irq
  );

endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO: a push is visible at the head one cycle later.
// A full FIFO takes a push only together with a pop; a pop while empty is ignored.
module ps2_evt_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 10,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_dat_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Stale storage survives reset, so the head is masked while nothing is queued.
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Folds E0/F0 prefixes into {ext,brk,code} events queued for the CPU; push on the final byte's edge,
// visible next cycle, irq one cycle later. A full FIFO drops events and sets sticky overflow.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 500000
) (
  input  logic           clk,
  input  logic           reset_n,
  ps2_kbd_ctrl_if.slave  bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ps2_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;
  logic             push;
  logic [EVT_W-1:0] push_dat;
  logic             is_ext, is_brk, drop;
  logic             fifo_full, fifo_empty;

  assign is_ext = (bus.rx_code == PS2_EXT);
  assign is_brk = (bus.rx_code == PS2_BRK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (bus.rx_valid) begin
      timer_d = '0;
      case (state_q)
        ST_IDLE:    state_d = is_ext ? ST_EXT : (is_brk ? ST_BRK : ST_IDLE);
        ST_EXT:     state_d = is_brk ? ST_EXT_BRK : (is_ext ? ST_EXT : ST_IDLE);
        ST_BRK:     state_d = is_ext ? ST_EXT_BRK : (is_brk ? ST_BRK : ST_IDLE);
        ST_EXT_BRK: state_d = (is_ext || is_brk) ? ST_EXT_BRK : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A prefix with no follow-up byte is abandoned rather than glued to a later key.
      if (timer_q == TW'(TIMEOUT - 1)) begin
        state_d = ST_IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_comb begin
    push     = bus.rx_valid && !is_ext && !is_brk;
    push_dat = mk_evt((state_q == ST_EXT) || (state_q == ST_EXT_BRK),
                      (state_q == ST_BRK) || (state_q == ST_EXT_BRK),
                      bus.rx_code);
  end

  // Full implies non-empty, so any rd_en frees the slot the push needs.
  assign drop  = push && fifo_full && !bus.rd_en;
  assign ovf_d = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);
  assign irq_d = bus.irq_en && !fifo_empty;

  ps2_evt_fifo #(.DEPTH(DEPTH), .WIDTH(EVT_W)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (bus.rd_en),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (bus.count),
    .head_dat_o (bus.evt_data)
  );

  assign bus.empty    = fifo_empty;
  assign bus.overflow = ovf_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: table of byte sequences plus hand-written corner cases,
// with expected events tracked in a scoreboard queue.
module tb_ps2_kbd_ctrl;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 20;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;
  logic [9:0] sb [$];

  ps2_kbd_ctrl_if #(.DEPTH(DEPTH)) bus ();

  ps2_kbd_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_code  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [9:0] e;
    e = sb.pop_front();
    check(name, {22'd0, bus.evt_data}, {22'd0, e});
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic drain(input string name);
    while (sb.size() > 0) pop_check(name);
    check({name, "_empty"}, {31'd0, bus.empty}, 32'd1);
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_code  = 8'h00;
    bus.rd_en    = 1'b0;
    bus.irq_en   = 1'b1;
    bus.ovf_clr  = 1'b0;

    vecs[0] = '{1, 8'h1C, 8'h00, 8'h00, 10'h01C};
    vecs[1] = '{3, 8'hE0, 8'hF0, 8'h75, 10'h375};
    vecs[2] = '{3, 8'hF0, 8'hE0, 8'h6B, 10'h36B};
    vecs[3] = '{2, 8'hF0, 8'h1C, 8'h00, 10'h11C};
    vecs[4] = '{3, 8'hE0, 8'hE0, 8'h1F, 10'h21F};
    vecs[5] = '{3, 8'hF0, 8'hF0, 8'h29, 10'h129};
    vecs[6] = '{3, 8'hE0, 8'hF0, 8'hF0, 10'h000};
    vecs[7] = '{1, 8'hAA, 8'h00, 8'h00, 10'h0AA};
    vecs[8] = '{2, 8'hE0, 8'hE1, 8'h00, 10'h2E1};
    vecs[9] = '{1, 8'hFA, 8'h00, 8'h00, 10'h0FA};

    #12;
    check("rst_evt",   {22'd0, bus.evt_data}, 32'h0);
    check("rst_empty", {31'd0, bus.empty},    32'd1);
    check("rst_count", {28'd0, bus.count},    32'd0);
    check("rst_ovf",   {31'd0, bus.overflow}, 32'd0);
    check("rst_irq",   {31'd0, bus.irq},      32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single key: visible next cycle, irq a cycle after that.
    send_byte(8'h1C);
    sb.push_back(10'h01C);
    check("t1_empty", {31'd0, bus.empty}, 32'd0);
    check("t1_count", {28'd0, bus.count}, 32'd1);
    check("t1_irq0",  {31'd0, bus.irq},   32'd0);
    tick();
    check("t1_irq1",  {31'd0, bus.irq},   32'd1);
    drain("t1_pop");

    // Table: vector 6 leaves the FSM in EXT_BRK; vector 7 then completes it.
    vecs[7].exp = 10'h3AA;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].n >= 1) send_byte(vecs[i].b0);
      if (vecs[i].n >= 2) send_byte(vecs[i].b1);
      if (vecs[i].n >= 3) send_byte(vecs[i].b2);
      if (i != 6) sb.push_back(vecs[i].exp);
      check($sformatf("vec%0d_count", i), {28'd0, bus.count}, sb.size());
      if (sb.size() == 3 || i == 9) drain($sformatf("vec%0d_pop", i));
    end

    // Timeout boundary: one cycle short keeps the prefix, a full TIMEOUT drops it.
    send_byte(8'hE0);
    repeat (TIMEOUT - 1) tick();
    send_byte(8'h1C);
    sb.push_back(10'h21C);
    drain("t3_short");
    send_byte(8'hE0);
    repeat (TIMEOUT) tick();
    send_byte(8'h1C);
    sb.push_back(10'h01C);
    check("t3_count", {28'd0, bus.count}, 32'd1);
    drain("t3_timeout");

    // Fill, overflow, push+pop when full, clear, set-wins.
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'h10 + 8'(i));
      sb.push_back(10'h010 + 10'(i));
    end
    check("t4_count_full", {28'd0, bus.count},    DEPTH);
    check("t4_ovf0",       {31'd0, bus.overflow}, 32'd0);
    send_byte(8'h55);
    check("t4_ovf1",       {31'd0, bus.overflow}, 32'd1);
    check("t4_count_drop", {28'd0, bus.count},    DEPTH);
    check("t4_head",       {22'd0, bus.evt_data}, 32'h010);
    bus.rd_en = 1'b1;
    send_byte(8'h66);
    bus.rd_en = 1'b0;
    void'(sb.pop_front());
    sb.push_back(10'h066);
    check("t4_count_pp",   {28'd0, bus.count},    DEPTH);
    check("t4_ovf_pp",     {31'd0, bus.overflow}, 32'd1);
    check("t4_head_pp",    {22'd0, bus.evt_data}, 32'h011);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t4_ovf_clr",    {31'd0, bus.overflow}, 32'd0);
    bus.ovf_clr = 1'b1;
    send_byte(8'h77);
    bus.ovf_clr = 1'b0;
    check("t4_set_wins",   {31'd0, bus.overflow}, 32'd1);
    drain("t4_pop");
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;

    // Pops while empty are ignored; push+pop on empty keeps the push.
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("t5_count_e", {28'd0, bus.count}, 32'd0);
    check("t5_empty_e", {31'd0, bus.empty}, 32'd1);
    bus.rd_en = 1'b1;
    send_byte(8'h2A);
    bus.rd_en = 1'b0;
    sb.push_back(10'h02A);
    check("t5_count_pe", {28'd0, bus.count},    32'd1);
    check("t5_head_pe",  {22'd0, bus.evt_data}, 32'h02A);
    tick();
    pop_check("t5_pop");
    check("t5_empty", {31'd0, bus.empty}, 32'd1);
    tick();
    check("t5_irq0",  {31'd0, bus.irq},   32'd0);

    // Reset with events queued and a break prefix pending.
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    send_byte(8'hF0);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("t6_empty", {31'd0, bus.empty},    32'd1);
    check("t6_count", {28'd0, bus.count},    32'd0);
    check("t6_irq",   {31'd0, bus.irq},      32'd0);
    check("t6_evt",   {22'd0, bus.evt_data}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    send_byte(8'h1C);
    sb.push_back(10'h01C);
    check("t6_count1", {28'd0, bus.count}, 32'd1);
    drain("t6_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
